oam_dma_mod: RTL and testbench

OAM DMA controller and data-bus arbiter for the Game Boy core. It sits between the CPU data-bus port (the `db_*` interface driven by the control unit) and the system memory bus. A CPU write to register 0xFF46 starts a copy of 160 bytes from `{src,8'h00}` to OAM at 0xFE00. While the copy runs, the block owns the bus and locks out the CPU.

---
 rtl/oam_dma_mod.sv | 138 +++++++++++++
 tb/tb_oam_dma_mod.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_mod.sv
// OAM DMA controller and CPU/system data-bus arbiter.
// A CPU write to the DMA register copies DMA_LEN bytes from {src,8'h00} into OAM while locking the CPU off the bus.
module oam_dma_mod #(
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int unsigned DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] cpu_db_address,
  input  logic [7:0]  cpu_db_data_out,
  input  logic        cpu_db_nwrite,
  input  logic        cpu_db_nread,
  output logic [7:0]  cpu_db_data_in,
  output logic [15:0] db_address,
  output logic [7:0]  db_data_out,
  output logic        db_nwrite,
  output logic        db_nread,
  input  logic [7:0]  db_data_in,
  output logic        dma_active
);

  localparam int unsigned IDX_W    = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       dma_src_q, dma_src_d;
  logic [7:0]       src_hi_q, src_hi_d;
  logic [7:0]       data_buf_q, data_buf_d;
  logic             nwrite_prev_q;

  logic reg_hit;
  logic trigger;

  assign reg_hit = (cpu_db_address == DMA_REG_ADDR);
  // Falling edge of the CPU write strobe onto the DMA register; a held strobe fires once.
  assign trigger = reg_hit && !cpu_db_nwrite && nwrite_prev_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      dma_src_q     <= 8'h00;
      src_hi_q      <= 8'h00;
      data_buf_q    <= 8'h00;
      nwrite_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dma_src_q     <= dma_src_d;
      src_hi_q      <= src_hi_d;
      data_buf_q    <= data_buf_d;
      nwrite_prev_q <= cpu_db_nwrite;
    end
  end

  // Next-state: transfer sequencing, with a trigger overriding any state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dma_src_d  = dma_src_q;
    src_hi_d   = src_hi_q;
    data_buf_d = data_buf_q;
    case (state_q)
      ST_START: state_d = ST_READ;
      ST_READ: begin
        state_d    = ST_WRITE;
        data_buf_d = db_data_in;
      end
      ST_WRITE: begin
        if (idx_q < LAST_IDX) begin
          state_d = ST_READ;
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (trigger) begin
      state_d   = ST_START;
      idx_d     = '0;
      dma_src_d = cpu_db_data_out;
      // Echo RAM (E000-FDFF) mirrors C000-DDFF.
      src_hi_d  = (cpu_db_data_out >= 8'hE0) ? (cpu_db_data_out - 8'h20) : cpu_db_data_out;
    end
  end

  // Bus mux: CPU pass-through in IDLE, DMA-owned bus otherwise.
  always_comb begin
    db_address     = cpu_db_address;
    db_data_out    = cpu_db_data_out;
    db_nwrite      = cpu_db_nwrite;
    db_nread       = cpu_db_nread;
    cpu_db_data_in = db_data_in;
    case (state_q)
      ST_IDLE: begin
        if (reg_hit) begin
          db_nwrite      = 1'b1;
          db_nread       = 1'b1;
          cpu_db_data_in = dma_src_q;
        end
      end
      ST_START: begin
        db_address     = 16'h0000;
        db_data_out    = 8'h00;
        db_nwrite      = 1'b1;
        db_nread       = 1'b1;
        cpu_db_data_in = reg_hit ? dma_src_q : 8'hFF;
      end
      ST_READ: begin
        db_address     = {src_hi_q, idx_q};
        db_data_out    = 8'h00;
        db_nwrite      = 1'b1;
        db_nread       = 1'b0;
        cpu_db_data_in = reg_hit ? dma_src_q : 8'hFF;
      end
      default: begin
        db_address     = OAM_BASE + 16'(idx_q);
        db_data_out    = data_buf_q;
        db_nwrite      = 1'b0;
        db_nread       = 1'b1;
        cpu_db_data_in = reg_hit ? dma_src_q : 8'hFF;
      end
    endcase
  end

  assign dma_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_oam_dma_mod.sv
// Bench for oam_dma_mod: byte-wide memory model on the system bus and a scoreboard of expected OAM writes.
module tb_oam_dma_mod;

  logic        clk;
  logic        nreset;
  logic [15:0] cpu_db_address;
  logic [7:0]  cpu_db_data_out;
  logic        cpu_db_nwrite;
  logic        cpu_db_nread;
  logic [7:0]  cpu_db_data_in;
  logic [15:0] db_address;
  logic [7:0]  db_data_out;
  logic        db_nwrite;
  logic        db_nread;
  logic [7:0]  db_data_in;
  logic        dma_active;

  oam_dma_mod dut (
    .clk             (clk),
    .nreset          (nreset),
    .cpu_db_address  (cpu_db_address),
    .cpu_db_data_out (cpu_db_data_out),
    .cpu_db_nwrite   (cpu_db_nwrite),
    .cpu_db_nread    (cpu_db_nread),
    .cpu_db_data_in  (cpu_db_data_in),
    .db_address      (db_address),
    .db_data_out     (db_data_out),
    .db_nwrite       (db_nwrite),
    .db_nread        (db_nread),
    .db_data_in      (db_data_in),
    .dma_active      (dma_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } sb_t;

  logic [7:0]  mem [0:65535];
  sb_t         sb [$];
  logic        sb_on;
  int          fe_cnt;
  int          errors;
  int          checks;
  logic        wr_v;
  logic [15:0] wr_a;
  logic [7:0]  wr_d;

  assign db_data_in = mem[db_address];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus model and write monitor: capture strobes at negedge, commit at posedge.
  always @(negedge clk) begin
    wr_v = !db_nwrite;
    wr_a = db_address;
    wr_d = db_data_out;
    if (!db_nwrite && db_address[15:8] == 8'hFE) begin
      fe_cnt++;
      if (sb_on) begin
        if (sb.size() == 0) begin
          chk("sb_extra_write", db_address, 16'hFFFF);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_addr", db_address, e.a);
          chk("sb_data", {8'h00, db_data_out}, {8'h00, e.d});
        end
      end
    end
  end

  always @(posedge clk) begin
    if (wr_v) mem[wr_a] <= wr_d;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle CPU write; returns in the cycle after the strobe.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    step();
    cpu_db_address  = a;
    cpu_db_data_out = d;
    cpu_db_nwrite   = 1'b0;
    step();
    cpu_db_nwrite   = 1'b1;
    cpu_db_address  = 16'h0000;
    cpu_db_data_out = 8'h00;
  endtask

  task automatic run_count(output int n);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!dma_active) break;
      n++;
    end
  endtask

  task automatic oam_check(input string tag, input logic [7:0] key);
    int bad;
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ key)) bad++;
    chk(tag, 16'(bad), 16'd0);
  endtask

  int cnt;
  int n;
  int fe_snap;

  initial begin
    errors = 0;
    checks = 0;
    fe_cnt = 0;
    sb_on  = 1'b0;
    wr_v   = 1'b0;
    wr_a   = 16'h0000;
    wr_d   = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h3C;
      mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'hC3;
    end
    cpu_db_address  = 16'h0000;
    cpu_db_data_out = 8'h00;
    cpu_db_nwrite   = 1'b1;
    cpu_db_nread    = 1'b1;
    nreset          = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;

    // Reset state and IDLE pass-through.
    @(negedge clk);
    chk("rst_dma_active", 16'(dma_active), 16'd0);
    step();
    cpu_db_address = 16'hFF46;
    cpu_db_nread   = 1'b0;
    @(negedge clk);
    chk("rst_ff46_read", {8'h00, cpu_db_data_in}, 16'h0000);
    chk("rst_ff46_not_fwd", 16'(db_nread), 16'd1);
    step();
    cpu_db_address = 16'hC000;
    @(negedge clk);
    chk("idle_read_c000", {8'h00, cpu_db_data_in}, 16'h005A);
    chk("idle_nread_fwd", 16'(db_nread), 16'd0);
    step();
    cpu_db_nread   = 1'b1;
    cpu_db_address = 16'h0000;

    // Full transfer from 0xC000 with lockout probes.
    for (int i = 0; i < 160; i++) sb.push_back({16'hFE00 + 16'(i), 8'(i) ^ 8'h5A});
    sb_on = 1'b1;
    cpu_write(16'hFF46, 8'hC0);
    @(negedge clk);
    chk("start_active", 16'(dma_active), 16'd1);
    chk("start_strobes", {14'd0, db_nread, db_nwrite}, 16'd3);
    step();
    cpu_db_address = 16'hC123;
    cpu_db_nread   = 1'b0;
    @(negedge clk);
    chk("first_read_addr", db_address, 16'hC000);
    chk("first_read_nread", 16'(db_nread), 16'd0);
    chk("lockout_read", {8'h00, cpu_db_data_in}, 16'h00FF);
    step();
    cpu_db_nread    = 1'b1;
    cpu_db_address  = 16'hD000;
    cpu_db_data_out = 8'h77;
    cpu_db_nwrite   = 1'b0;
    @(negedge clk);
    chk("lockout_bus_addr", db_address, 16'hFE00);
    step();
    cpu_db_nwrite   = 1'b1;
    cpu_db_address  = 16'h0000;
    cpu_db_data_out = 8'h00;
    run_count(n);
    cnt = 3 + n;
    chk("full_active_cycles", 16'(cnt), 16'd321);
    chk("sb_drained_full", 16'(sb.size()), 16'd0);
    oam_check("oam_full", 8'h5A);
    chk("lockout_d000", {8'h00, mem[16'hD000]}, 16'h00C3);
    sb.delete();

    // Echo fold: 0xE1 sources from 0xC100, register reads back 0xE1.
    for (int i = 0; i < 160; i++) sb.push_back({16'hFE00 + 16'(i), 8'(i) ^ 8'h3C});
    cpu_write(16'hFF46, 8'hE1);
    step();
    @(negedge clk);
    chk("echo_read_addr", db_address, 16'hC100);
    step();
    cpu_db_address = 16'hFF46;
    cpu_db_nread   = 1'b0;
    @(negedge clk);
    chk("echo_reg_during", {8'h00, cpu_db_data_in}, 16'h00E1);
    step();
    cpu_db_nread   = 1'b1;
    cpu_db_address = 16'h0000;
    run_count(n);
    step();
    cpu_db_address = 16'hFF46;
    cpu_db_nread   = 1'b0;
    @(negedge clk);
    chk("echo_reg_after", {8'h00, cpu_db_data_in}, 16'h00E1);
    step();
    cpu_db_nread   = 1'b1;
    cpu_db_address = 16'h0000;
    chk("sb_drained_echo", 16'(sb.size()), 16'd0);
    oam_check("oam_echo", 8'h3C);
    sb_on = 1'b0;
    sb.delete();

    // Restart mid-transfer with a new source.
    cpu_write(16'hFF46, 8'hC0);
    repeat (49) step();
    cpu_write(16'hFF46, 8'hD0);
    @(negedge clk);
    chk("restart_start", {14'd0, db_nread, db_nwrite}, 16'd3);
    step();
    @(negedge clk);
    chk("restart_read_addr", db_address, 16'hD000);
    step();
    run_count(n);
    cnt = 2 + n;
    chk("restart_active_cycles", 16'(cnt), 16'd321);
    oam_check("oam_restart", 8'hC3);

    // Asynchronous reset in the middle of a transfer.
    cpu_write(16'hFF46, 8'hC0);
    repeat (98) step();
    #2 nreset = 1'b0;
    #1;
    chk("midrst_active", 16'(dma_active), 16'd0);
    chk("midrst_strobes", {14'd0, db_nread, db_nwrite}, 16'd3);
    fe_snap = fe_cnt;
    repeat (2) step();
    nreset = 1'b1;
    repeat (400) step();
    chk("midrst_no_fe_writes", 16'(fe_cnt - fe_snap), 16'd0);
    chk("midrst_idle", 16'(dma_active), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
